// File: rtl/alu_pkg.sv
// Shared ALU definitions: shifter operation codes, flag bit positions and
// the skid-buffer state encoding used by the shifter result stage.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [1:0] OP_NONE   = 2'b00;
    localparam logic [1:0] OP_LEFT   = 2'b01;
    localparam logic [1:0] OP_RIGHT  = 2'b10;
    localparam logic [1:0] OP_ARIGHT = 2'b11;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/shift_result_stage_if.sv
// Handshake and payload bundle between the barrel shifter, the result stage
// and the writeback consumer; the stage itself connects through the slave modport.
interface shift_result_stage_if #(
    parameter int N = 32
);
    localparam int B = $clog2(N);

    logic         valid_i;
    logic         ready_o;
    logic [N-1:0] number_i;
    logic [B-1:0] shift_amount_i;
    logic [1:0]   operation_i;
    logic [N-1:0] shift_number_i;
    logic         valid_o;
    logic         ready_i;
    logic [N-1:0] result_o;
    logic [1:0]   op_o;
    logic [2:0]   flags_o;

    modport master (
        output valid_i, number_i, shift_amount_i, operation_i, shift_number_i, ready_i,
        input  ready_o, valid_o, result_o, op_o, flags_o
    );

    modport slave (
        input  valid_i, number_i, shift_amount_i, operation_i, shift_number_i, ready_i,
        output ready_o, valid_o, result_o, op_o, flags_o
    );

endinterface

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: full throughput with in_ready_o
// decoded purely from state flops, so no combinational path from out_ready_i.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter int W = 37
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    // NOTE: both data registers are reset as well, because the output
    // register is visible on the ports and must read zero after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SKID_EMPTY;
            data_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        // NOTE: hold-value defaults first, so no path leaves a latch behind.
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    state_d = SKID_ONE;
                    data_d  = in_data_i;
                end
            end
            SKID_ONE: begin
                if (in_fire && out_fire) begin
                    data_d = in_data_i;
                end else if (in_fire) begin
                    state_d = SKID_FULL;
                    skid_d  = in_data_i;
                end else if (out_fire) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // Skid entry is older than anything upstream, so it drains first.
                if (out_fire) begin
                    state_d = SKID_ONE;
                    data_d  = skid_q;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q != SKID_FULL);
        out_valid_o = (state_q != SKID_EMPTY);
        out_data_o  = data_q;
    end

endmodule

// File: rtl/shift_result_stage.sv
// Registered output stage after the barrel shifter: derives {C,N,Z} and queues
// result+op+flags in a skid buffer. `define SHIFT_RESULT_STATS_EN adds transfer/stall counters.
module shift_result_stage
    import alu_pkg::*;
#(
    parameter int N = ALU_WIDTH,
    parameter int B = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    shift_result_stage_if.slave  bus
`ifdef SHIFT_RESULT_STATS_EN
    ,
    output logic [31:0]          accept_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int W = N + 2 + 3;

    logic [B-1:0] left_idx;
    logic [B-1:0] right_idx;
    logic         carry;
    logic [2:0]   flags;
    logic [W-1:0] in_payload;
    logic [W-1:0] out_payload;

    // Carry is the last bit shifted out of the source operand.
    always_comb begin
        left_idx  = B'(N - int'(bus.shift_amount_i));
        right_idx = bus.shift_amount_i - B'(1);
        carry     = 1'b0;
        if (bus.shift_amount_i != '0) begin
            unique case (bus.operation_i)
                OP_LEFT:            carry = bus.number_i[left_idx];
                OP_RIGHT, OP_ARIGHT: carry = bus.number_i[right_idx];
                default:            carry = 1'b0;
            endcase
        end
        flags         = '0;
        flags[FLAG_Z] = (bus.shift_number_i == '0);
        flags[FLAG_N] = bus.shift_number_i[N-1];
        flags[FLAG_C] = carry;
    end

    assign in_payload = {bus.shift_number_i, bus.operation_i, flags};

    alu_skid_buf #(
        .W (W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (bus.valid_i),
        .in_ready_o  (bus.ready_o),
        .in_data_i   (in_payload),
        .out_valid_o (bus.valid_o),
        .out_ready_i (bus.ready_i),
        .out_data_o  (out_payload)
    );

    assign bus.result_o = out_payload[W-1 -: N];
    assign bus.op_o     = out_payload[4:3];
    assign bus.flags_o  = out_payload[2:0];

`ifdef SHIFT_RESULT_STATS_EN
    logic [31:0] accept_cnt_q, accept_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        accept_cnt_d = accept_cnt_q + ((bus.valid_o && bus.ready_i) ? 32'd1 : 32'd0);
        stall_cnt_d  = stall_cnt_q + ((bus.valid_o && !bus.ready_i) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            accept_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            accept_cnt_q <= accept_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign accept_cnt_o = accept_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: doc/shift_result_stage.md
Name: shift_result_stage

Overview:
- Registered output stage directly downstream of the barrel shifter in the 32-bit ALU datapath.
- Captures the shifter result together with its source operand, shift amount and operation code.
- Derives the Z/N/C flags and presents result plus flags to the writeback consumer through a valid/ready handshake.
- A 2-entry skid buffer decouples shifter timing from consumer backpressure, so throughput is 1 result/cycle with no combinational ready path.

Parameters:
- N, 32, datapath width
- B, $clog2(N), shift-amount width

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  synchronous active-low reset
- valid_i  input  1  upstream result valid
- ready_o  output  1  stage can accept; registered
- number_i  input  N  unshifted source operand, used for carry extraction
- shift_amount_i  input  B  shift amount applied upstream
- operation_i  input  2  00 none, 01 LEFT, 10 RIGHT, 11 ARIGHT
- shift_number_i  input  N  shifter result
- valid_o  output  1  output result valid
- ready_i  input  1  downstream accepts
- result_o  output  N  registered result
- op_o  output  2  registered operation code
- flags_o  output  3  {C,N,Z}, registered

Behaviour:
- Reset (rst_ni low at a clock edge):
  - valid_o=0, result_o=0, op_o=0, flags_o=0.
  - Skid entry is emptied; ready_o=1 from the first edge after reset.
  - Reset mid-operation discards both entries; no partial output is produced.
- Handshake:
  - An input transfer happens when valid_i && ready_o.
  - An output transfer happens when valid_o && ready_i.
  - valid_o and the payload hold stable until the output transfer completes.
- Flag rules, computed on the input side from the values present at the input transfer:
  - Z = (shift_number_i == 0).
  - N = shift_number_i[N-1].
  - C for LEFT with amt != 0: number_i[N-amt].
  - C for RIGHT or ARIGHT with amt != 0: number_i[amt-1].
  - C = 0 for op 00 or amt == 0.
- Buffer states: EMPTY, ONE (output register holds data), FULL (output register and skid entry both hold data).
  - EMPTY + input transfer -> ONE; valid_o rises on the next cycle (latency 1).
  - ONE + input transfer + output transfer -> ONE; new data moves to the output register.
  - ONE + input transfer without output transfer -> FULL; data goes into the skid entry; ready_o drops the next cycle.
  - ONE + output transfer only -> EMPTY.
  - FULL + output transfer -> ONE; skid data moves to the output register; ready_o returns to 1 the next cycle.
  - FULL: ready_o=0, so no input transfer is possible.
- Ordering is strictly FIFO; no result is ever dropped or duplicated.
- valid_i asserted while ready_o=0: no transfer. Upstream holds its data.

Optional Feature:
- Macro: SHIFT_RESULT_STATS_EN.
- Defined:
  - Adds output accept_cnt_o[31:0], counting output transfers.
  - Adds output stall_cnt_o[31:0], counting cycles with valid_o && !ready_i.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Package alu_pkg:
  - Operation localparams OP_NONE=2'b00, OP_LEFT=2'b01, OP_RIGHT=2'b10, OP_ARIGHT=2'b11, shared with the barrel shifter.
  - Flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2.
  - Default width constant 32.
- Sub-module alu_skid_buf: generic 2-entry valid/ready skid buffer with parameter W.
  - Instantiated with W = N+2+3 (result, op, flags).
  - Flag and carry logic stays in the top module.

Test Plan:
- Reset check: hold rst_ni=0 for 3 cycles with valid_i=1 -> valid_o=0, flags_o=0, result_o=0; ready_o=1 after release.
- Carry, LEFT: number_i=32'h8000_0001, op=01, amt=1, shift_number_i=32'h0000_0002, ready_i=1 -> next cycle valid_o=1, result_o=32'h2, flags_o=3'b100.
- Carry and flags, ARIGHT: number_i=32'h8000_0000, op=11, amt=31, shift_number_i=32'hFFFF_FFFF -> flags_o=3'b010.
- Zero flag: RIGHT of 32'h1 by amt=1 with shift_number_i=0 -> flags_o=3'b101.
- Backpressure: stream values 1,2,3,4 with ready_i=0 for 4 cycles -> ready_o drops after the 2nd accept; after ready_i=1, outputs arrive in order 1,2,3,4 with no loss or duplication.
- Throughput and stats: 100 back-to-back transfers with random ready_i -> in-order data, no bubbles whenever ready_i=1. With SHIFT_RESULT_STATS_EN defined, accept_cnt_o=100 and stall_cnt_o equals the number of cycles with valid_o=1 && ready_i=0.
